// File: rtl/xaui_link_recovery_pkg.sv
// +--------------------------------------------------------------------------+
// | xaui_link_recovery_pkg : shared types and constants for link recovery    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package xaui_link_recovery_pkg;

  typedef enum logic [2:0] {
    ST_LOOK    = 3'd0,
    ST_RX_RST  = 3'd1,
    ST_RX_WAIT = 3'd2,
    ST_TX_RST  = 3'd3,
    ST_TX_WAIT = 3'd4
  } state_e;

  localparam int DEF_N_LANES        = 4;
  localparam int DEF_SW             = 5;
  localparam int DEF_WAIT_BITS      = 24;
  localparam int DEF_STRETCH        = 15;
  localparam int DEF_MAX_RX_RETRIES = 3;

  localparam int REC_W     = 16;
  localparam int ESC_W     = 8;
  localparam int STRETCH_W = 8;

endpackage

`default_nettype wire

// File: rtl/xaui_link_recovery.sv
// +--------------------------------------------------------------------------+
// | xaui_link_recovery : XAUI MGT reset sequencer with RX->TX escalation     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module xaui_link_recovery
  import xaui_link_recovery_pkg::*;
#(
  parameter int N_LANES        = DEF_N_LANES,
  parameter int SW             = DEF_SW,
  parameter int WAIT_BITS      = DEF_WAIT_BITS,
  parameter int STRETCH        = DEF_STRETCH,
  parameter int MAX_RX_RETRIES = DEF_MAX_RX_RETRIES
) (
  input  logic               xaui_clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               force_reset,
  input  logic [SW-1:0]      link_ok,
  input  logic [N_LANES-1:0] lane_sync,
  output logic [N_LANES-1:0] mgt_rx_reset,
  output logic [N_LANES-1:0] mgt_tx_reset,
  output logic               status_clear,
  output logic               link_up,
  output logic [REC_W-1:0]   recoveries,
  output logic [ESC_W-1:0]   escalations
);

  localparam int CW = (WAIT_BITS > STRETCH_W) ? WAIT_BITS : STRETCH_W;
  localparam int AW = $clog2(MAX_RX_RETRIES + 1);

  localparam logic [CW-1:0] STRETCH_LOAD = CW'(STRETCH);
  localparam logic [CW-1:0] WAIT_LOAD    = CW'((64'd1 << WAIT_BITS) - 64'd1);
  localparam logic [AW-1:0] ATT_MAX      = AW'(MAX_RX_RETRIES);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_LANES-1:0] mask_q, mask_d;
  logic [AW-1:0]      att_q, att_d;
  logic [REC_W-1:0]   rec_q, rec_d;
  logic [ESC_W-1:0]   esc_q, esc_d;
  logic [N_LANES-1:0] rx_q, rx_d;
  logic [N_LANES-1:0] tx_q, tx_d;
  logic               link_up_q, link_up_d;

  logic               fault;
  logic [N_LANES-1:0] lost_lanes;
  logic [N_LANES-1:0] new_mask;
  logic               cnt_done;

  assign fault      = (link_ok != {SW{1'b1}}) || force_reset;
  assign lost_lanes = ~lane_sync;
  // A link fault with every lane still in sync gives no target, so hit all lanes.
  assign new_mask   = (lost_lanes == '0) ? {N_LANES{1'b1}} : lost_lanes;
  assign cnt_done   = (cnt_q <= CW'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    att_d     = att_q;
    rec_d     = rec_q;
    esc_d     = esc_q;
    rx_d      = '0;
    tx_d      = '0;
    link_up_d = 1'b0;

    case (state_q)
      ST_LOOK: begin
        link_up_d = !fault;
        if (enable) begin
          if (!fault) begin
            att_d = '0;
          end else if (att_q < ATT_MAX) begin
            mask_d  = new_mask;
            rx_d    = new_mask;
            cnt_d   = STRETCH_LOAD;
            att_d   = att_q + AW'(1);
            if (rec_q != {REC_W{1'b1}}) rec_d = rec_q + REC_W'(1);
            state_d = ST_RX_RST;
          end else begin
            rx_d    = {N_LANES{1'b1}};
            tx_d    = {N_LANES{1'b1}};
            cnt_d   = STRETCH_LOAD;
            att_d   = '0;
            if (esc_q != {ESC_W{1'b1}}) esc_d = esc_q + ESC_W'(1);
            state_d = ST_TX_RST;
          end
        end
      end

      // Outputs are registered from the next-state view, so they drop on the
      // same edge the counter expires.
      ST_RX_RST: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_done) begin
          cnt_d   = WAIT_LOAD;
          state_d = ST_RX_WAIT;
        end else begin
          rx_d = mask_q;
        end
      end

      ST_TX_RST: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_done) begin
          cnt_d   = WAIT_LOAD;
          state_d = ST_TX_WAIT;
        end else begin
          rx_d = {N_LANES{1'b1}};
          tx_d = {N_LANES{1'b1}};
        end
      end

      ST_RX_WAIT, ST_TX_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = ST_LOOK;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_LOOK;
      end
    endcase
  end

  always_ff @(posedge xaui_clk) begin
    if (reset) begin
      state_q   <= ST_LOOK;
      cnt_q     <= '0;
      mask_q    <= '0;
      att_q     <= '0;
      rec_q     <= '0;
      esc_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      link_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      att_q     <= att_d;
      rec_q     <= rec_d;
      esc_q     <= esc_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      link_up_q <= link_up_d;
    end
  end

  assign mgt_rx_reset = rx_q;
  assign mgt_tx_reset = tx_q;
  assign status_clear = |rx_q;
  assign link_up      = link_up_q;
  assign recoveries   = rec_q;
  assign escalations  = esc_q;

endmodule

`default_nettype wire

// File: tb/tb_xaui_link_recovery.sv
// +--------------------------------------------------------------------------+
// | tb_xaui_link_recovery : directed self-checking bench for link recovery   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_xaui_link_recovery;

  localparam int N_LANES        = 4;
  localparam int SW             = 5;
  localparam int WAIT_BITS      = 4;
  localparam int STRETCH        = 3;
  localparam int MAX_RX_RETRIES = 2;
  localparam int WAIT_CYC       = 1 << WAIT_BITS;

  logic               xaui_clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               force_reset;
  logic [SW-1:0]      link_ok;
  logic [N_LANES-1:0] lane_sync;
  logic [N_LANES-1:0] mgt_rx_reset;
  logic [N_LANES-1:0] mgt_tx_reset;
  logic               status_clear;
  logic               link_up;
  logic [15:0]        recoveries;
  logic [7:0]         escalations;

  int checks = 0;
  int errors = 0;

  xaui_link_recovery #(
    .N_LANES        (N_LANES),
    .SW             (SW),
    .WAIT_BITS      (WAIT_BITS),
    .STRETCH        (STRETCH),
    .MAX_RX_RETRIES (MAX_RX_RETRIES)
  ) dut (
    .xaui_clk     (xaui_clk),
    .reset        (reset),
    .enable       (enable),
    .force_reset  (force_reset),
    .link_ok      (link_ok),
    .lane_sync    (lane_sync),
    .mgt_rx_reset (mgt_rx_reset),
    .mgt_tx_reset (mgt_tx_reset),
    .status_clear (status_clear),
    .link_up      (link_up),
    .recoveries   (recoveries),
    .escalations  (escalations)
  );

  always #5 xaui_clk = ~xaui_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Fault must already be presented; the next edge samples it in LOOK.
  task automatic expect_seq(input logic [3:0] rx, input logic [3:0] tx,
                            input int rec, input int esc, input bit heal);
    for (int i = 0; i < STRETCH; i++) begin
      @(negedge xaui_clk);
      check("seq_rx", 32'(mgt_rx_reset), 32'(rx));
      check("seq_tx", 32'(mgt_tx_reset), 32'(tx));
      check("seq_status_clear", 32'(status_clear), 32'(rx != 4'h0));
      check("seq_link_up", 32'(link_up), 32'd0);
      if (i == 0 && heal) begin
        link_ok     = 5'h1F;
        force_reset = 1'b0;
        lane_sync   = 4'hF;
      end
    end
    check("seq_recoveries", 32'(recoveries), 32'(rec));
    check("seq_escalations", 32'(escalations), 32'(esc));
    for (int i = 0; i < WAIT_CYC; i++) begin
      @(negedge xaui_clk);
      check("wait_rx", 32'(mgt_rx_reset), 32'd0);
      check("wait_tx", 32'(mgt_tx_reset), 32'd0);
      check("wait_status_clear", 32'(status_clear), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    enable      = 1'b1;
    force_reset = 1'b0;
    link_ok     = 5'h1F;
    lane_sync   = 4'hF;
    repeat (3) @(negedge xaui_clk);

    check("rst_rx", 32'(mgt_rx_reset), 32'd0);
    check("rst_tx", 32'(mgt_tx_reset), 32'd0);
    check("rst_status_clear", 32'(status_clear), 32'd0);
    check("rst_link_up", 32'(link_up), 32'd0);
    check("rst_recoveries", 32'(recoveries), 32'd0);
    check("rst_escalations", 32'(escalations), 32'd0);

    // Healthy link: link_up rises one edge after release.
    reset = 1'b0;
    @(negedge xaui_clk);
    check("healthy_link_up", 32'(link_up), 32'd1);
    repeat (5) begin
      @(negedge xaui_clk);
      check("healthy_rx", 32'(mgt_rx_reset), 32'd0);
      check("healthy_tx", 32'(mgt_tx_reset), 32'd0);
    end
    check("healthy_recoveries", 32'(recoveries), 32'd0);

    // Single-cycle fault, lane 1 out of sync; lane_sync heals during RX_RST.
    link_ok   = 5'h1B;
    lane_sync = 4'b1101;
    expect_seq(4'b0010, 4'h0, 1, 0, 1'b1);
    @(negedge xaui_clk);
    check("after_rx1_link_up", 32'(link_up), 32'd1);

    // Fault with all lanes synced: every lane is reset.
    link_ok = 5'h0F;
    expect_seq(4'hF, 4'h0, 2, 0, 1'b1);
    @(negedge xaui_clk);
    check("after_rx2_link_up", 32'(link_up), 32'd1);

    // Persistent fault: two RX tries, then TX escalation, then RX again.
    link_ok = 5'h00;
    expect_seq(4'hF, 4'h0, 3, 0, 1'b0);
    expect_seq(4'hF, 4'h0, 4, 0, 1'b0);
    expect_seq(4'hF, 4'hF, 4, 1, 1'b0);
    @(negedge xaui_clk);
    check("post_esc_rx", 32'(mgt_rx_reset), 32'hF);
    check("post_esc_tx", 32'(mgt_tx_reset), 32'h0);
    check("post_esc_recoveries", 32'(recoveries), 32'd5);
    check("post_esc_escalations", 32'(escalations), 32'd1);

    // Reset during the second cycle of RX_RST.
    @(negedge xaui_clk);
    check("rx_rst_cycle2", 32'(mgt_rx_reset), 32'hF);
    reset   = 1'b1;
    link_ok = 5'h1F;
    @(negedge xaui_clk);
    check("midrst_rx", 32'(mgt_rx_reset), 32'd0);
    check("midrst_tx", 32'(mgt_tx_reset), 32'd0);
    check("midrst_status_clear", 32'(status_clear), 32'd0);
    check("midrst_recoveries", 32'(recoveries), 32'd0);
    check("midrst_escalations", 32'(escalations), 32'd0);
    check("midrst_link_up", 32'(link_up), 32'd0);
    reset = 1'b0;
    @(negedge xaui_clk);
    check("midrst_look_link_up", 32'(link_up), 32'd1);

    // Disabled with persistent fault: nothing happens.
    enable  = 1'b0;
    link_ok = 5'h00;
    repeat (20) begin
      @(negedge xaui_clk);
      check("dis_rx", 32'(mgt_rx_reset), 32'd0);
      check("dis_tx", 32'(mgt_tx_reset), 32'd0);
      check("dis_link_up", 32'(link_up), 32'd0);
    end
    check("dis_recoveries", 32'(recoveries), 32'd0);
    check("dis_escalations", 32'(escalations), 32'd0);

    // Re-enable: sequence starts on the edge that samples enable high.
    enable = 1'b1;
    expect_seq(4'hF, 4'h0, 1, 0, 1'b1);
    @(negedge xaui_clk);
    check("reen_link_up", 32'(link_up), 32'd1);

    // force_reset pulse on a healthy link.
    force_reset = 1'b1;
    lane_sync   = 4'hF;
    expect_seq(4'hF, 4'h0, 2, 0, 1'b1);
    @(negedge xaui_clk);
    check("force_link_up", 32'(link_up), 32'd1);
    check("force_escalations", 32'(escalations), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/xaui_link_recovery.md
# xaui_link_recovery

Parametrised link-recovery controller between a XAUI core's status outputs and its per-lane MGT reset inputs. It watches link-health bits and per-lane sync and issues stretched RX resets, targeted at the lanes that lost sync. It holds off re-checking for a programmable interval. After repeated failed RX recoveries it escalates to a combined TX+RX reset, and it exports link-up and recovery statistics.

## Interface
Parameters:
- N_LANES, 4, number of MGT lanes
- SW, 5, width of link-health vector; link is healthy only when all SW bits are 1
- WAIT_BITS, 24, hold-off counter width; hold-off lasts 2^WAIT_BITS cycles
- STRETCH, 15, reset pulse length in cycles (1..255)
- MAX_RX_RETRIES, 3, consecutive failed RX recoveries before TX escalation (>=1)

Ports:
- xaui_clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- enable  in  1  0 freezes detection in LOOK; in-flight sequences complete
- force_reset  in  1  level; treated as a link fault while in LOOK
- link_ok  in  SW  XAUI status health bits
- lane_sync  in  N_LANES  per-lane sync-OK
- mgt_rx_reset  out  N_LANES  per-lane RX reset, registered
- mgt_tx_reset  out  N_LANES  per-lane TX reset, registered
- status_clear  out  1  high whenever any mgt_rx_reset bit is high; drives the core's link/fault-status reset bits
- link_up  out  1  registered; 1 in LOOK with healthy link
- recoveries  out  16  saturating count of RX sequences started
- escalations  out  8  saturating count of TX sequences started

## Operation
- States: LOOK, RX_RST, RX_WAIT, TX_RST, TX_WAIT.
- Fault condition: `(link_ok != all-ones) || force_reset`.
- LOOK, fault, enable=1, attempts<MAX_RX_RETRIES:
  - lane mask = ~lane_sync, captured once here.
  - If the captured mask is all-zero, use all-ones instead.
  - Load the stretch counter with STRETCH; attempts++; recoveries++ (saturating); go to RX_RST.
- LOOK, fault, enable=1, attempts==MAX_RX_RETRIES:
  - Load STRETCH; attempts cleared; escalations++ (saturating); go to TX_RST.
- LOOK, no fault:
  - attempts cleared; link_up=1.
  - In every other state, and in LOOK with a fault, link_up=0.
- LOOK, enable=0: no transition; attempts unchanged.
- RX_RST:
  - mgt_rx_reset = captured mask.
  - Stretch counter decrements each cycle; on reaching 0, load the wait counter with 2^WAIT_BITS-1 and go to RX_WAIT.
- TX_RST:
  - mgt_tx_reset and mgt_rx_reset both all-ones for STRETCH cycles, then go to TX_WAIT the same way.
- RX_WAIT / TX_WAIT:
  - All resets low; wait counter decrements each cycle; at 0, go to LOOK.
  - Link health is ignored during the wait.
- Counters saturate; they never wrap.
- Attempt counter width: $clog2(MAX_RX_RETRIES+1).

## Timing
- Reset:
  - state=LOOK; all mgt_*_reset=0; status_clear=0; link_up=0.
  - attempts, recoveries and escalations = 0; counters = 0.
  - Takes effect mid-sequence too: any asserted reset output drops on the cycle after reset is sampled.
- Fault sampled in LOOK at edge t:
  - reset outputs high from edge t+1 for exactly STRETCH cycles.
  - Then low for exactly 2^WAIT_BITS cycles.
  - Fault is resampled at the first LOOK edge after that.
- link_up rises one cycle after a healthy sample in LOOK.
- link_up falls one cycle after a faulty sample in LOOK or on leaving LOOK.
- Fault and enable falling on the same edge: enable wins, no sequence starts.
- lane_sync changes during RX_RST do not alter the captured mask.
- Back-to-back faults: successive RX sequences are separated by one LOOK cycle.

## Structure
- Package xaui_link_recovery_pkg holds:
  - state enum (LOOK, RX_RST, RX_WAIT, TX_RST, TX_WAIT)
  - default parameter constants
  - counter saturation widths (16, 8)
- No sub-module: the FSM, one shared down-counter (max of WAIT_BITS and 8 bits), the mask register and the statistics counters sit inline.

## Test plan
Use WAIT_BITS=4, STRETCH=3, MAX_RX_RETRIES=2, N_LANES=4, SW=5.
- Healthy link after reset (link_ok=5'h1F, lane_sync=4'hF) → link_up=1 at cycle 2; no resets ever; recoveries=0.
- link_ok=5'h1B one cycle, lane_sync=4'b1101 → mgt_rx_reset=4'b0010 for exactly 3 cycles; status_clear matches; then 16 cycles low; recoveries=1.
- Link fault with lane_sync=4'hF → mgt_rx_reset=4'hF for 3 cycles.
- Persistent fault → two RX sequences (recoveries=2), then TX_RST: tx and rx resets both 4'hF for 3 cycles; escalations=1; next fault starts an RX sequence again (attempts cleared).
- Assert reset on the second cycle of RX_RST → all resets 0 next cycle; counters 0; state LOOK.
- enable=0 with persistent fault → no resets and no counter changes.
- Re-enable → RX sequence starts the cycle after enable is sampled high.
- force_reset pulse with healthy link and lane_sync=4'hF → one full RX sequence on all lanes.
